// File: rtl/proj001_pkg.sv
// proj001_pkg
// Shared definitions for the proj001 calculator interface: default operand and
// result widths, the operation codes understood by the proj001 controller, the
// sequencer state encoding and a small width helper.
// Ports: none (package).
package proj001_pkg;

    localparam int DW_DEF = 4;
    localparam int RW_DEF = DW_DEF + 1;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MAX = 2'd2,
        OP_MIN = 2'd3
    } op_code_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_GAP  = 3'd2,
        S_WAIT = 3'd3,
        S_RESP = 3'd4
    } seq_state_t;

    // Counter width that stays >= 1 bit even for a range of one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/proj001_seq_timer.sv
// proj001_seq_timer
// Loadable down-counter with a terminal-count flag. Used by the sequencer both
// for capture-pulse spacing and for the response timeout.
// Ports:
//   clock     in   rising-edge clock
//   rst       in   synchronous active-high reset (count -> 0)
//   load      in   load load_val this cycle (has priority over en)
//   en        in   decrement while nonzero
//   load_val  in   W-bit reload value
//   tc        out  terminal count, high while the count is zero
module proj001_seq_timer #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/proj001_seq_driver.sv
// proj001_seq_driver
// Initiator side of the proj001 calculator interface. Accepts a request of one
// op plus NUM_OPS packed operands, strobes the operands out one per capture
// pulse (CAP_GAP idle cycles apart), waits for the calculator's valid and
// returns the result, or a timeout flag if no valid arrives within TIMEOUT
// cycles. All outputs are registered.
// Ports:
//   clock, rst              clock and synchronous active-high reset
//   req_valid/req_ready     request handshake
//   req_op, req_data        op code and operands (operand 0 in the LSBs, sent first)
//   d_in, op, capture       operand, op and one-cycle capture strobe to proj001
//   valid, result           proj001 result qualifier and value
//   rsp_valid/rsp_ready     response handshake
//   rsp_result, rsp_timeout latched result (0 on timeout) and timeout flag
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | req_ready high, waiting for a request
// LOAD   | capture pulse with d_in = operand[idx]
// GAP    | CAP_GAP idle cycles between capture pulses, d_in held
// WAIT   | waiting for valid, timeout timer running
// RESP   | response presented until rsp_ready
module proj001_seq_driver
    import proj001_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int RW      = RW_DEF,
    parameter int NUM_OPS = 4,
    parameter int CAP_GAP = 1,
    parameter int TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DW*NUM_OPS-1:0] req_data,
    output logic [DW-1:0]         d_in,
    output logic [1:0]            op,
    output logic                  capture,
    input  logic                  valid,
    input  logic [RW-1:0]         result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [RW-1:0]         rsp_result,
    output logic                  rsp_timeout
);

    localparam int IW = cnt_width(NUM_OPS);
    localparam int GW = 3;
    localparam int TW = cnt_width(TIMEOUT);

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OPS - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((CAP_GAP > 0) ? CAP_GAP - 1 : 0);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

    seq_state_t    state, next_state;
    logic [DW-1:0] shadow [NUM_OPS];
    logic [IW-1:0] idx;
    logic [IW-1:0] sel_idx;
    logic [DW-1:0] next_operand;
    logic          gap_load, gap_tc;
    logic          tmo_load, tmo_tc;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (req_valid) next_state = S_LOAD;
            S_LOAD: begin
                if (idx == LAST_IDX)  next_state = S_WAIT;
                else if (CAP_GAP > 0) next_state = S_GAP;
                else                  next_state = S_LOAD;
            end
            S_GAP:  if (gap_tc) next_state = S_LOAD;
            // valid takes priority over an expiring timer in the same cycle
            S_WAIT: if (valid || tmo_tc) next_state = S_RESP;
            S_RESP: if (rsp_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // idx is only advanced when leaving LOAD, so a back-to-back LOAD needs
    // idx+1 while a GAP->LOAD already sees the advanced index.
    always_comb begin
        sel_idx      = (state == S_LOAD) ? idx + IW'(1) : idx;
        next_operand = shadow[sel_idx];
    end

    assign gap_load = (state == S_LOAD) && (next_state == S_GAP);
    assign tmo_load = (state == S_LOAD) && (next_state == S_WAIT);

    proj001_seq_timer #(.W(GW)) u_gap_timer (
        .clock    (clock),
        .rst      (rst),
        .load     (gap_load),
        .en       (state == S_GAP),
        .load_val (GAP_LOAD),
        .tc       (gap_tc)
    );

    proj001_seq_timer #(.W(TW)) u_tmo_timer (
        .clock    (clock),
        .rst      (rst),
        .load     (tmo_load),
        .en       (state == S_WAIT),
        .load_val (TMO_LOAD),
        .tc       (tmo_tc)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            for (int i = 0; i < NUM_OPS; i++) shadow[i] <= '0;
            req_ready   <= 1'b1;
            d_in        <= '0;
            op          <= '0;
            capture     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state     <= next_state;
            // Strobes follow the state they belong to, so they line up with it.
            req_ready <= (next_state == S_IDLE);
            capture   <= (next_state == S_LOAD);
            rsp_valid <= (next_state == S_RESP);
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        for (int i = 0; i < NUM_OPS; i++) shadow[i] <= req_data[i*DW +: DW];
                        op   <= req_op;
                        idx  <= '0;
                        d_in <= req_data[DW-1:0];
                    end
                end
                S_LOAD: begin
                    if (idx != LAST_IDX) begin
                        idx <= idx + IW'(1);
                        if (CAP_GAP == 0) d_in <= next_operand;
                    end
                end
                S_GAP: begin
                    if (gap_tc) d_in <= next_operand;
                end
                S_WAIT: begin
                    if (valid) begin
                        rsp_result  <= result;
                        rsp_timeout <= 1'b0;
                    end else if (tmo_tc) begin
                        rsp_result  <= '0;
                        rsp_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
